fibonacci_seq: RTL and testbench
================================

// Module: fibonacci_seq
// PURPOSE
//  Parametrised, host-seeded additive-sequence generator (Fibonacci, Lucas, any x0/x1 seed).
//  Emits N terms on a valid/ready stream. Each term carries a per-term wrap (overflow) flag.
//  Sits behind a command interface; replaces the free-running fixed 32b generator.
// PARAMETERS
//  W      32  term width in bits; sums are truncated modulo 2^W
//  CNT_W  16  width of the term-count field; max 2^CNT_W-1 terms per command
// PORTS
//  clk        in   1      clock; one clock domain
//  rst_n      in   1      reset; synchronous, active-low
//  start_vld  in   1      command valid
//  start_rdy  out  1      command ready; 1 only in IDLE
//  start_a    in   W      seed term 0
//  start_b    in   W      seed term 1
//  start_n    in   CNT_W  number of terms to emit
//  out_vld    out  1      term valid
//  out_rdy    in   1      term ready (downstream backpressure)
//  out_data   out  W      current term
//  out_last   out  1      final term of the command
//  out_ovf    out  1      term has wrapped modulo 2^W, or follows a wrapped term
//  busy       out  1      FSM is in RUN
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FSM->IDLE; all regs 0.
//   Outputs: start_rdy=1, out_vld=0, out_last=0, out_ovf=0, out_data=0, busy=0.
//   Reset mid-sequence aborts the sequence; no partial term is held over.
//  FSM IDLE:
//   start_vld&start_rdy with n!=0 -> load x0=a, x1=b, ovf0=ovf1=0, rem=n; go RUN.
//   start_vld&start_rdy with n==0 -> accepted, no terms emitted, stay IDLE.
//  FSM RUN: start_rdy=0; start_vld is ignored (no queueing).
//   out_vld=1, out_data=x0, out_ovf=ovf0, out_last=(rem==1).
//  Handshake (out_vld&out_rdy):
//   x0<=x1; {c,x1}<=x0+x1 (W+1-bit add, carry c)
//   ovf0<=ovf1; ovf1<=c|ovf0|ovf1 (sticky once wrapped); rem<=rem-1
//   If out_last: go IDLE (start_rdy=1 on the next cycle).
//  Backpressure: with out_vld&!out_rdy, out_data/out_last/out_ovf hold stable; no state advances.
//  Latency: command accepted at cycle T -> first term valid at T+1.
//   Throughput: 1 term/cycle when out_rdy=1. No bubble between terms.
//  Back-to-back: a new command is acceptable the cycle after the last handshake.
//   Minimum gap is 1 idle cycle.
// CONFIGURATION
//  FIBONACCI_SEQ_OVF_STOP_EN defined:
//   The first term with out_ovf=1 is forced out_last=1, regardless of rem.
//   That term is emitted, then the FSM goes to IDLE.
//  FIBONACCI_SEQ_OVF_STOP_EN undefined:
//   Terms wrap modulo 2^W; out_ovf is informational only; exactly n terms are emitted.
// STRUCTURE
//  Package fibonacci_seq_pkg: state_t enum {IDLE, RUN}.
//  Sub-module fibonacci_seq_dp: datapath only.
//   Holds the x0/x1 regs, the ovf0/ovf1 regs, the W+1-bit adder, and load/shift enables.
//  Top-level fibonacci_seq: FSM, rem counter, handshake and last/ovf-stop logic.
// TESTING
//  1. W=32; a=0, b=1, n=10; out_rdy=1 -> 0,1,1,2,3,5,8,13,21,34.
//     out_last only on 34; all out_ovf=0; 10 consecutive cycles.
//  2. Lucas: a=2, b=1, n=5 -> 2,1,3,4,7; then start_rdy=1 the cycle after the last handshake.
//  3. W=8; a=0, b=1, n=16; STOP_EN undefined -> terms ...144,233,121,98.
//     out_ovf=1 on 121 and 98 only; 16 terms.
//     Same test with STOP_EN defined -> 15 terms; 121 has out_last=1 and out_ovf=1.
//  4. Case 1 with random out_rdy (50%) -> data stable while stalled; identical sequence; no drops.
//  5. n=0 -> start accepted; out_vld stays 0; start_rdy stays 1.
//     Also: start_vld during RUN is ignored.
//  6. Case 1 with rst_n=0 after the 4th term -> next cycle out_vld=0, start_rdy=1.
//     A new command (a=0, b=1, n=3) then yields 0,1,1.

Source files
------------

// File: rtl/fibonacci_seq_pkg.sv
// Shared types for the additive-sequence generator.
package fibonacci_seq_pkg;

    // Controller states: waiting for a command, or streaming terms.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fibonacci_seq_dp.sv
// Datapath for fibonacci_seq: the two-term window, its wrap flags and the adder.
// No control decisions are made here; load and shift come from the top-level FSM.
module fibonacci_seq_dp
    import fibonacci_seq_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] seed_a,
    input  logic [W-1:0] seed_b,
    output logic [W-1:0] term,
    output logic         term_ovf
);

    logic [W-1:0] x0_q;
    logic [W-1:0] x1_q;
    logic         ovf0_q;
    logic         ovf1_q;
    logic [W:0]   sum;

    // Carry out of the W-bit sum marks the first wrapped term.
    assign sum = {1'b0, x0_q} + {1'b0, x1_q};

    // Window registers: seed on load, slide one term forward on shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x0_q   <= '0;
            x1_q   <= '0;
            ovf0_q <= 1'b0;
            ovf1_q <= 1'b0;
        end else if (load) begin
            x0_q   <= seed_a;
            x1_q   <= seed_b;
            ovf0_q <= 1'b0;
            ovf1_q <= 1'b0;
        end else if (shift) begin
            x0_q   <= x1_q;
            x1_q   <= sum[W-1:0];
            ovf0_q <= ovf1_q;
            // Sticky: once any term wrapped, every later term is flagged too.
            ovf1_q <= sum[W] | ovf0_q | ovf1_q;
        end
    end

    assign term     = x0_q;
    assign term_ovf = ovf0_q;

endmodule

// File: rtl/fibonacci_seq.sv
// Host-seeded additive-sequence generator (Fibonacci, Lucas, arbitrary seeds).
// Accepts {a, b, n} on a command handshake and streams n terms on a valid/ready port.
// Optional build macro FIBONACCI_SEQ_OVF_STOP_EN: end the command at the first wrapped term.
module fibonacci_seq
    import fibonacci_seq_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_vld,
    output logic             start_rdy,
    input  logic [W-1:0]     start_a,
    input  logic [W-1:0]     start_b,
    input  logic [CNT_W-1:0] start_n,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    output logic             out_ovf,
    output logic             busy
);

    state_t           state_q;
    logic [CNT_W-1:0] rem_q;
    logic             vld_q;
    logic             rdy_q;
    logic             busy_q;

    logic             load;
    logic             shift;
    logic             last;
    logic             term_ovf;
    logic [W-1:0]     term;

    // rdy_q is high exactly in IDLE, so it doubles as the IDLE decode.
    // A zero-length command is accepted but never loads the datapath.
    assign load  = rdy_q & start_vld & (start_n != '0);
    assign shift = vld_q & out_rdy;

`ifdef FIBONACCI_SEQ_OVF_STOP_EN
    // The first flagged term closes the command even if rem is not exhausted.
    assign last = vld_q & ((rem_q == CNT_W'(1)) | term_ovf);
`else
    assign last = vld_q & (rem_q == CNT_W'(1));
`endif

    fibonacci_seq_dp #(
        .W (W)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .shift    (shift),
        .seed_a   (start_a),
        .seed_b   (start_b),
        .term     (term),
        .term_ovf (term_ovf)
    );

    // Control FSM with registered handshake/status flags and the remaining-term count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= RUN;
                        rem_q   <= start_n;
                        vld_q   <= 1'b1;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (shift) begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (last) begin
                            state_q <= IDLE;
                            vld_q   <= 1'b0;
                            rdy_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign start_rdy = rdy_q;
    assign out_vld   = vld_q;
    assign busy      = busy_q;
    assign out_data  = term;
    assign out_last  = last;
    // Stale flag left in the window after a command ends is not shown while idle.
    assign out_ovf   = vld_q & term_ovf;

endmodule

// File: tb/tb_fibonacci_seq.sv
// Self-checking bench for fibonacci_seq: one 32-bit and one 8-bit instance.
module tb_fibonacci_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        sv32, srdy32, vld32, ordy32, last32, ovf32, busy32;
    logic [31:0] a32, b32, d32;
    logic [15:0] n32;

    logic        sv8, srdy8, vld8, ordy8, last8, ovf8, busy8;
    logic [7:0]  a8, b8, d8;
    logic [15:0] n8;

    fibonacci_seq #(.W(32), .CNT_W(16)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start_vld(sv32), .start_rdy(srdy32),
        .start_a(a32), .start_b(b32), .start_n(n32), .out_vld(vld32), .out_rdy(ordy32),
        .out_data(d32), .out_last(last32), .out_ovf(ovf32), .busy(busy32)
    );

    fibonacci_seq #(.W(8), .CNT_W(16)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start_vld(sv8), .start_rdy(srdy8),
        .start_a(a8), .start_b(b8), .start_n(n8), .out_vld(vld8), .out_rdy(ordy8),
        .out_data(d8), .out_last(last8), .out_ovf(ovf8), .busy(busy8)
    );

    typedef struct {
        longint unsigned data;
        bit              last;
        bit              ovf;
    } term_t;

    term_t           exp32[$];
    term_t           exp8[$];
    term_t           mq[$];
    longint unsigned log32[$];
    longint unsigned log8[$];
    bit              ovflog8[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: true (unbounded) sequence values; a term is flagged once its true
    // value no longer fits in w bits, and the emitted data is that value mod 2^w.
    task automatic build(input longint unsigned a, input longint unsigned b, input int n,
                         input int w);
        longint unsigned t0 = a;
        longint unsigned t1 = b;
        longint unsigned nt;
        longint unsigned lim = 64'd1 << w;
        mq.delete();
        for (int i = 0; i < n; i++) begin
            term_t t;
            t.data = t0 % lim;
            t.ovf  = (t0 >= lim);
            t.last = (i == n - 1);
`ifdef FIBONACCI_SEQ_OVF_STOP_EN
            if (t.ovf) t.last = 1'b1;
`endif
            mq.push_back(t);
            if (t.last) break;
            nt = t0 + t1;
            t0 = t1;
            t1 = nt;
        end
    endtask

    // Drive a command for one cycle; expected terms become due once it is accepted.
    task automatic issue(input bit is8, input longint unsigned a, input longint unsigned b,
                         input int n);
        if (is8) begin
            check("start_rdy8_before_cmd", srdy8, 1);
            sv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; n8 = n[15:0];
            build(a, b, n, 8);
        end else begin
            check("start_rdy32_before_cmd", srdy32, 1);
            sv32 = 1'b1; a32 = a[31:0]; b32 = b[31:0]; n32 = n[15:0];
            build(a, b, n, 32);
        end
        @(posedge clk);
        foreach (mq[i]) begin
            if (is8) exp8.push_back(mq[i]);
            else     exp32.push_back(mq[i]);
        end
        #1;
        sv8  = 1'b0;
        sv32 = 1'b0;
    endtask

    task automatic wait_idle(input bit is8, input string name);
        int k = 0;
        while ((is8 ? exp8.size() : exp32.size()) != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, (k < 200) ? 1 : 0, 1);
    endtask

    // Per-cycle comparison of both instances against the expected-term queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("out_vld32", vld32, exp32.size() != 0);
            check("busy32", busy32, exp32.size() != 0);
            check("start_rdy32", srdy32, exp32.size() == 0);
            if (vld32 && exp32.size() != 0) begin
                check("out_data32", d32, exp32[0].data);
                check("out_last32", last32, exp32[0].last);
                check("out_ovf32", ovf32, exp32[0].ovf);
                if (ordy32) begin
                    log32.push_back(d32);
                    void'(exp32.pop_front());
                end
            end
            check("out_vld8", vld8, exp8.size() != 0);
            check("busy8", busy8, exp8.size() != 0);
            check("start_rdy8", srdy8, exp8.size() == 0);
            if (vld8 && exp8.size() != 0) begin
                check("out_data8", d8, exp8[0].data);
                check("out_last8", last8, exp8[0].last);
                check("out_ovf8", ovf8, exp8[0].ovf);
                if (ordy8) begin
                    log8.push_back(d8);
                    ovflog8.push_back(ovf8);
                    void'(exp8.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        sv32 = 1'b0; a32 = '0; b32 = '0; n32 = '0; ordy32 = 1'b1;
        sv8  = 1'b0; a8  = '0; b8  = '0; n8  = '0; ordy8  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_rdy", srdy32, 1);
        check("rst_out_vld", vld32, 0);
        check("rst_out_last", last32, 0);
        check("rst_out_ovf", ovf32, 0);
        check("rst_out_data", d32, 0);
        check("rst_busy", busy32, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain Fibonacci, full throughput
        log32.delete();
        issue(0, 0, 1, 10);
        check("t1_first_valid", vld32, 1);
        repeat (10) @(posedge clk);
        #1;
        check("t1_done_in_10", exp32.size(), 0);
        check("t1_count", log32.size(), 10);
        check("t1_term3", log32[3], 2);
        check("t1_term9", log32[9], 34);

        // Lucas, then immediate back-to-back command acceptance
        log32.delete();
        issue(0, 2, 1, 5);
        repeat (5) @(posedge clk);
        #1;
        check("t2_rdy_after_last", srdy32, 1);
        check("t2_term2", log32[2], 3);
        check("t2_term4", log32[4], 7);

        // 32-bit wrap boundary
        log32.delete();
        issue(0, 64'hFFFF_FFF0, 64'h20, 4);
        wait_idle(0, "t2b_drain");
        check("t2b_wrapped_term", log32[2], 64'h10);
`ifdef FIBONACCI_SEQ_OVF_STOP_EN
        check("t2b_count", log32.size(), 3);
`else
        check("t2b_count", log32.size(), 4);
`endif

        // 8-bit wrap
        log8.delete();
        ovflog8.delete();
        issue(1, 0, 1, 16);
        wait_idle(1, "t3_drain");
        check("t3_term13", log8[13], 233);
        check("t3_term14", log8[14], 121);
        check("t3_ovf13", ovflog8[13], 0);
        check("t3_ovf14", ovflog8[14], 1);
`ifdef FIBONACCI_SEQ_OVF_STOP_EN
        check("t3_count", log8.size(), 15);
`else
        check("t3_count", log8.size(), 16);
        check("t3_term15", log8[15], 98);
`endif

        // Random backpressure
        log32.delete();
        issue(0, 0, 1, 10);
        for (int k = 0; k < 300 && exp32.size() != 0; k++) begin
            ordy32 = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        ordy32 = 1'b1;
        check("t4_drained", exp32.size(), 0);
        check("t4_count", log32.size(), 10);
        check("t4_term9", log32[9], 34);

        // Zero-length command
        issue(0, 7, 7, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_n0_vld", vld32, 0);
        check("t5_n0_rdy", srdy32, 1);

        // start_vld during RUN is dropped
        log32.delete();
        issue(0, 5, 8, 4);
        sv32 = 1'b1; a32 = 32'd99; b32 = 32'd99; n32 = 16'd2;
        @(posedge clk);
        #1;
        sv32 = 1'b0;
        wait_idle(0, "t5_drain");
        repeat (2) @(posedge clk);
        #1;
        check("t5_count", log32.size(), 4);
        check("t5_term3", log32[3], 21);

        // Reset mid-sequence
        issue(0, 0, 1, 10);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp32.delete();
        log32.delete();
        rst_n = 1'b1;
        check("t6_vld_after_rst", vld32, 0);
        check("t6_rdy_after_rst", srdy32, 1);
        check("t6_data_after_rst", d32, 0);
        issue(0, 0, 1, 3);
        wait_idle(0, "t6_drain");
        check("t6_count", log32.size(), 3);
        check("t6_term0", log32[0], 0);
        check("t6_term2", log32[2], 1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
